dll_tap_ctrl: RTL and testbench

- Sequential tap controller for the tapped delay line in the clock path.
- Turns phase-detector early/late votes, or a manual code, into the one-hot per-cell enable vector that drives the delay chain's OR tree.
- Filters votes, saturates at chain ends, and switches taps make-before-break so the OR-tree output never drops out.
- Reports lock status.

---
 rtl/dll_pkg.sv | 21 ++
 rtl/dll_tap_decoder.sv | 14 +
 rtl/dll_tap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dll_tap_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared types and sizing helpers for the DLL tap controller.
package dll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OVERLAP,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // Signed vote accumulator width: must hold +/-FILT_TH with one bit of margin.
    function automatic int acc_width(input int filt_th);
        return $clog2(filt_th) + 2;
    endfunction

endpackage

// File: rtl/dll_tap_decoder.sv
// Binary tap code to one-hot delay-cell enable vector.
module dll_tap_decoder
    import dll_pkg::*;
#(
    parameter int TAPS   = 512,
    parameter int CODE_W = $clog2(TAPS)
) (
    input  logic [CODE_W-1:0] code,
    output logic [TAPS-1:0]   onehot
);

    assign onehot = TAPS'(1) << code;

endmodule

// File: rtl/dll_tap_ctrl.sv
// Tap controller: filters phase-detector votes or manual codes into a
// make-before-break one-hot enable vector for the delay chain.
module dll_tap_ctrl
    import dll_pkg::*;
#(
    parameter int TAPS     = 512,
    parameter int CODE_W   = $clog2(TAPS),
    parameter int INIT_TAP = TAPS / 2,
    parameter int FILT_TH  = 8,
    parameter int HOLD     = 4,
    parameter int LOCK_CNT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pd_valid,
    input  logic              pd_early,
    input  logic              pd_late,
    input  logic              mode,
    input  logic              man_load,
    input  logic [CODE_W-1:0] man_code,
    input  logic              freeze,
    output logic [TAPS-1:0]   en,
    output logic [CODE_W-1:0] tap_code,
    output logic              locked,
    output logic              at_min,
    output logic              at_max
);

    localparam int ACC_W = acc_width(FILT_TH);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam int HLD_W = $clog2(HOLD + 1);

    localparam logic signed [ACC_W-1:0] TH_POS  = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG  = -TH_POS;
    localparam logic [CODE_W-1:0]       TAP_MAX = CODE_W'(TAPS - 1);
    localparam logic [CODE_W-1:0]       TAP_RST = CODE_W'(INIT_TAP);
    localparam logic [TAPS-1:0]         EN_RST  = TAPS'(1) << INIT_TAP;
    localparam logic [LCK_W-1:0]        LCK_MAX = LCK_W'(LOCK_CNT);

    state_t                   state, state_nxt;
    logic [HLD_W-1:0]         hold_cnt, hold_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt, acc_sum;
    logic [LCK_W-1:0]         lock_cnt, lock_nxt;
    dir_t                     last_dir, dir_nxt, dir_req;
    logic [CODE_W-1:0]        new_tap, new_nxt, tap_nxt, target, man_clamped, new_sel;
    logic [TAPS-1:0]          en_nxt, oh_old, oh_new;
    logic                     mode_q, mode_chg, load;

    dll_tap_decoder #(.TAPS(TAPS), .CODE_W(CODE_W)) u_dec_old (
        .code   (tap_code),
        .onehot (oh_old)
    );

    assign new_sel = (state == ST_IDLE) ? target : new_tap;

    dll_tap_decoder #(.TAPS(TAPS), .CODE_W(CODE_W)) u_dec_new (
        .code   (new_sel),
        .onehot (oh_new)
    );

    assign mode_chg    = (mode != mode_q);
    assign man_clamped = ({1'b0, man_code} >= (CODE_W + 1)'(TAPS)) ? TAP_MAX : man_code;

    // Vote filter, manual load and lock bookkeeping; produces the switch request.
    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        acc_nxt  = acc;
        lock_nxt = lock_cnt;
        dir_nxt  = last_dir;
        acc_sum  = acc;
        dir_req  = DIR_NONE;
        target   = tap_code;
        load     = 1'b0;

        if (mode_chg) begin
            acc_nxt  = '0;
            lock_nxt = '0;
        end else if (state == ST_IDLE && !freeze) begin
            if (mode) begin
                acc_nxt = '0;
                if (man_load) begin
                    target = man_clamped;
                    load   = (man_clamped != tap_code);
                end
            end else if (pd_valid && (pd_early ^ pd_late)) begin
                acc_sum = pd_early ? acc + ACC_W'(1) : acc - ACC_W'(1);
                acc_nxt = acc_sum;
                if (acc_sum == TH_POS)      dir_req = DIR_UP;
                else if (acc_sum == TH_NEG) dir_req = DIR_DOWN;

                if (dir_req != DIR_NONE) begin
                    acc_nxt = '0;
                    if ((dir_req == DIR_UP && tap_code == TAP_MAX) ||
                        (dir_req == DIR_DOWN && tap_code == '0)) begin
                        lock_nxt = '0;
                    end else begin
                        target  = (dir_req == DIR_UP) ? tap_code + 1'b1 : tap_code - 1'b1;
                        load    = 1'b1;
                        dir_nxt = dir_req;
                        if (last_dir == dir_req)
                            lock_nxt = '0;
                        else if (last_dir != DIR_NONE && lock_cnt != LCK_MAX)
                            lock_nxt = lock_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Switch sequencer: old|new for one cycle, then new alone, then settle.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        new_nxt   = new_tap;
        tap_nxt   = tap_code;
        en_nxt    = en;

        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    new_nxt   = target;
                    en_nxt    = oh_old | oh_new;
                    state_nxt = ST_OVERLAP;
                end
            end
            ST_OVERLAP: begin
                tap_nxt   = new_tap;
                en_nxt    = oh_new;
                hold_nxt  = HLD_W'(HOLD - 1);
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == '0) state_nxt = ST_IDLE;
                else                hold_nxt  = hold_cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            acc      <= '0;
            lock_cnt <= '0;
            last_dir <= DIR_NONE;
            new_tap  <= TAP_RST;
            tap_code <= TAP_RST;
            en       <= EN_RST;
            locked   <= 1'b0;
            at_min   <= (TAP_RST == '0);
            at_max   <= (TAP_RST == TAP_MAX);
            mode_q   <= mode;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            acc      <= acc_nxt;
            lock_cnt <= lock_nxt;
            last_dir <= dir_nxt;
            new_tap  <= new_nxt;
            tap_code <= tap_nxt;
            en       <= en_nxt;
            locked   <= (lock_nxt == LCK_MAX);
            at_min   <= (tap_nxt == '0);
            at_max   <= (tap_nxt == TAP_MAX);
            mode_q   <= mode;
        end
    end

endmodule

// File: tb/tb_dll_tap_ctrl.sv
// Randomised and directed bench for dll_tap_ctrl against a cycle-level
// behavioural model built from the tap-switching rules.
module tb_dll_tap_ctrl;

    localparam int TAPS     = 512;
    localparam int CODE_W   = 9;
    localparam int INIT_TAP = 256;
    localparam int FILT_TH  = 8;
    localparam int HOLD     = 4;
    localparam int LOCK_CNT = 6;
    localparam int TAPS2    = 20;
    localparam int CODE_W2  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              pd_valid = 1'b0, pd_early = 1'b0, pd_late = 1'b0;
    logic              mode = 1'b0, man_load = 1'b0, freeze = 1'b0;
    logic [CODE_W-1:0] man_code = '0;
    logic [TAPS-1:0]   en;
    logic [CODE_W-1:0] tap_code;
    logic              locked, at_min, at_max;

    logic               z_valid = 1'b0, z_early = 1'b0, z_late = 1'b0, z_freeze = 1'b0;
    logic               mode2 = 1'b1, man_load2 = 1'b0;
    logic [CODE_W2-1:0] man_code2 = '0;
    logic [TAPS2-1:0]   en2;
    logic [CODE_W2-1:0] tap_code2;
    logic               locked2, at_min2, at_max2;

    dll_tap_ctrl #(
        .TAPS(TAPS), .CODE_W(CODE_W), .INIT_TAP(INIT_TAP),
        .FILT_TH(FILT_TH), .HOLD(HOLD), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk), .rst(rst), .pd_valid(pd_valid), .pd_early(pd_early), .pd_late(pd_late),
        .mode(mode), .man_load(man_load), .man_code(man_code), .freeze(freeze),
        .en(en), .tap_code(tap_code), .locked(locked), .at_min(at_min), .at_max(at_max)
    );

    // Non-power-of-two chain so that out-of-range manual codes are representable.
    dll_tap_ctrl #(.TAPS(TAPS2), .CODE_W(CODE_W2)) dut2 (
        .clk(clk), .rst(rst), .pd_valid(z_valid), .pd_early(z_early), .pd_late(z_late),
        .mode(mode2), .man_load(man_load2), .man_code(man_code2), .freeze(z_freeze),
        .en(en2), .tap_code(tap_code2), .locked(locked2), .at_min(at_min2), .at_max(at_max2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_vec(input string name, input logic [TAPS-1:0] act, input logic [TAPS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [TAPS-1:0] oh(input int i);
        logic [TAPS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Behavioural model: committed tap, pending tap and a busy countdown
    // (HOLD+1 = overlap cycle showing, then HOLD settle cycles).
    int m_tap, m_new, m_busy, m_acc, m_cnt, m_last, m_mode_prev;
    bit m_locked;
    bit cmp_on = 1'b0;

    task automatic m_start(input int t);
        m_new  = t;
        m_busy = HOLD + 1;
    endtask

    task automatic model_step();
        if (rst) begin
            m_tap = INIT_TAP; m_new = INIT_TAP; m_busy = 0; m_acc = 0;
            m_cnt = 0; m_last = 0; m_mode_prev = int'(mode); cmp_on = 1'b1;
        end else begin
            bit mchg;
            mchg = (int'(mode) != m_mode_prev);
            if (mchg) begin
                m_acc = 0;
                m_cnt = 0;
            end
            if (m_busy > 0) begin
                if (m_busy == HOLD + 1) m_tap = m_new;
                m_busy--;
            end else if (!mchg && !freeze) begin
                if (mode) begin
                    m_acc = 0;
                    if (man_load) begin
                        int t;
                        t = (int'(man_code) > TAPS - 1) ? TAPS - 1 : int'(man_code);
                        if (t != m_tap) m_start(t);
                    end
                end else if (pd_valid && (pd_early != pd_late)) begin
                    int d;
                    d = pd_early ? 1 : -1;
                    m_acc += d;
                    if (m_acc == d * FILT_TH) begin
                        m_acc = 0;
                        if (m_tap + d < 0 || m_tap + d > TAPS - 1) begin
                            m_cnt = 0;
                        end else begin
                            m_start(m_tap + d);
                            if (m_last == d) m_cnt = 0;
                            else if (m_last != 0 && m_cnt < LOCK_CNT) m_cnt++;
                            m_last = d;
                        end
                    end
                end
            end
            m_mode_prev = int'(mode);
        end
        m_locked = (m_cnt == LOCK_CNT);
    endtask

    task automatic compare();
        logic [TAPS-1:0] e;
        e = oh(m_tap);
        if (m_busy == HOLD + 1) e = e | oh(m_new);
        check_vec("en", en, e);
        check_int("tap_code", int'(tap_code), m_tap);
        check_int("locked", int'(locked), int'(m_locked));
        check_int("at_min", int'(at_min), (m_tap == 0) ? 1 : 0);
        check_int("at_max", int'(at_max), (m_tap == TAPS - 1) ? 1 : 0);
        check_int("en_max_two_hot", ($countones(en) <= 2) ? 1 : 0, 1);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) compare();
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pd_valid = 1'b0; pd_early = 1'b0; pd_late = 1'b0; man_load = 1'b0; freeze = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mode = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    task automatic vote(input int n, input logic e, input logic l);
        for (int i = 0; i < n; i++) begin
            pd_valid = 1'b1; pd_early = e; pd_late = l;
            tick();
        end
    endtask

    initial begin
        int bias;

        // Reset state
        tick();
        do_reset();
        check_vec("rst_en", en, oh(256));
        check_int("rst_tap", int'(tap_code), 256);
        check_int("rst_locked", int'(locked), 0);
        check_int("rst_at_min", int'(at_min), 0);
        check_int("rst_at_max", int'(at_max), 0);

        // Filtered up-step, make-before-break, votes dropped while busy
        vote(8, 1'b1, 1'b0);
        check_vec("up_overlap", en, oh(256) | oh(257));
        vote(1, 1'b1, 1'b0);
        check_vec("up_onehot", en, oh(257));
        check_int("up_tap", int'(tap_code), 257);
        vote(4 + 7, 1'b1, 1'b0);
        check_vec("busy_votes_dropped", en, oh(257));
        vote(1, 1'b1, 1'b0);
        check_vec("second_step_overlap", en, oh(257) | oh(258));
        idle_inputs();
        repeat (HOLD + 2) tick();

        // Manual jumps and clamping
        do_reset();
        mode = 1'b1;
        tick();
        man_code = 9'd3; man_load = 1'b1;
        tick();
        check_vec("man_overlap", en, oh(256) | oh(3));
        man_load = 1'b0;
        tick();
        check_vec("man_onehot", en, oh(3));
        check_int("man_tap", int'(tap_code), 3);
        repeat (HOLD + 1) tick();
        man_code = 9'd511; man_load = 1'b1;
        tick();
        man_load = 1'b0;
        tick();
        check_int("man_max_tap", int'(tap_code), 511);
        check_int("man_at_max", int'(at_max), 1);
        man_code2 = 5'd25; man_load2 = 1'b1;
        tick();
        man_load2 = 1'b0;
        tick();
        check_int("clamp_tap", int'(tap_code2), TAPS2 - 1);
        check_int("clamp_at_max", int'(at_max2), 1);
        repeat (HOLD + 1) tick();
        man_load = 1'b1;
        tick();
        man_load = 1'b0;
        check_vec("man_same_tap_no_overlap", en, oh(511));
        mode = 1'b0;
        tick();
        vote(30, 1'b1, 1'b0);
        check_vec("saturate_max", en, oh(511));
        idle_inputs();
        tick();

        // Lock acquisition and loss
        do_reset();
        for (int s = 0; s < 7; s++) begin
            if (s % 2 == 0) vote(8, 1'b1, 1'b0);
            else            vote(8, 1'b0, 1'b1);
            if (s == 5) check_int("lock_not_yet", int'(locked), 0);
            if (s == 6) check_int("lock_set", int'(locked), 1);
            idle_inputs();
            repeat (HOLD + 2) tick();
        end
        vote(8, 1'b1, 1'b0);
        check_int("lock_lost", int'(locked), 0);
        idle_inputs();
        repeat (HOLD + 2) tick();

        // Reset during OVERLAP
        do_reset();
        vote(8, 1'b1, 1'b0);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("rst_mid_overlap_en", en, oh(256));
        vote(7, 1'b1, 1'b0);
        idle_inputs();
        repeat (3) tick();
        check_vec("rst_cleared_acc", en, oh(256));

        // Conflicting votes and freeze
        do_reset();
        vote(20, 1'b1, 1'b1);
        idle_inputs();
        tick();
        check_int("both_votes_tap", int'(tap_code), 256);
        freeze = 1'b1;
        vote(20, 1'b1, 1'b0);
        check_int("freeze_tap", int'(tap_code), 256);
        idle_inputs();
        tick();

        // Randomised traffic
        bias = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) bias = $urandom_range(20, 80);
            rst      = ($urandom_range(0, 299) == 0);
            pd_valid = ($urandom_range(0, 9) < 8);
            pd_early = ($urandom_range(0, 99) < bias);
            pd_late  = ($urandom_range(0, 99) >= bias);
            if ($urandom_range(0, 249) == 0) mode = ~mode;
            if ($urandom_range(0, 99) == 0)  freeze = ~freeze;
            man_load = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       man_code = '0;
                1:       man_code = CODE_W'(TAPS - 1);
                2:       man_code = CODE_W'(m_tap);
                default: man_code = CODE_W'($urandom_range(0, TAPS - 1));
            endcase
            tick();
        end
        idle_inputs();
        repeat (HOLD + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
